// File: rtl/rnd_mask_scheduler_pkg.sv
// Shared constants for the random mask scheduler: word width, probability
// mask table, probability encodings and FSM state encodings.
package rnd_mask_scheduler_pkg;

  localparam int RNDSIZE = 7;
  localparam int RND_W   = RNDSIZE * (RNDSIZE - 1) / 2;

  // Probability select encodings
  localparam logic [1:0] PROB_00 = 2'b00;
  localparam logic [1:0] PROB_01 = 2'b01;
  localparam logic [1:0] PROB_10 = 2'b10;
  localparam logic [1:0] PROB_11 = 2'b11;

  // 16-bit mask constants, aligned to the top of the word by the user
  localparam logic [15:0] MASK_P00 = 16'hFFFF;
  localparam logic [15:0] MASK_P01 = 16'h03FF;
  localparam logic [15:0] MASK_P10 = 16'h07FF;
  localparam logic [15:0] MASK_P11 = 16'h1FFF;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READY  = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  // Map a probability select onto its 16-bit mask constant
  function automatic logic [15:0] mask16(input logic [1:0] p);
    logic [15:0] m;
    case (p)
      PROB_00: m = MASK_P00;
      PROB_01: m = MASK_P01;
      PROB_10: m = MASK_P10;
      PROB_11: m = MASK_P11;
      default: m = MASK_P00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rnd_mask_scheduler_lfsr_comb.sv
// Combinational LFSR step and probability mask. Produces the next seed and
// the masked random word derived from it.
module rnd_mask_scheduler_lfsr_comb
  import rnd_mask_scheduler_pkg::*;
#(
  parameter int W = RND_W
) (
  input  logic [W-1:0] seed,
  input  logic [1:0]   probability,
  output logic [W-1:0] nxt,
  output logic [W-1:0] rnd
);

  logic         fb;
  logic [W-1:0] mask;

  // One LFSR shift with taps W-1,3,2,0, then XOR with the top-aligned mask
  always_comb begin
    fb   = seed[W-1] ^ seed[3] ^ seed[2] ^ seed[0];
    nxt  = {seed[W-2:0], fb};
    mask = W'(mask16(probability)) << (W - 16);
    rnd  = nxt ^ mask;
  end

endmodule

// File: rtl/rnd_mask_scheduler.sv
// Round-robin scheduler sharing one LFSR seed among N requesters. Each grant
// advances the seed once and presents one masked word until accepted.
module rnd_mask_scheduler
  import rnd_mask_scheduler_pkg::*;
#(
  parameter int W               = RND_W,
  parameter int N               = 4,
  parameter int IDW             = 2,
  parameter int RESEED_INTERVAL = 256,
  parameter int CNT_W           = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           seed_load,
  input  logic [W-1:0]   seed_in,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] prob,
  output logic [N-1:0]   gnt,
  output logic           rnd_valid,
  input  logic           rnd_ready,
  output logic [W-1:0]   rnd_out,
  output logic [IDW-1:0] rnd_id,
  output logic           reseed_req,
  output logic           locked
);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     seed_q, seed_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     out_q, out_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   rr_q, rr_d;

  logic [IDW-1:0]   arb_idx;
  logic [IDW-1:0]   win;
  logic             found;
  logic [1:0]       prob_sel;
  logic [W-1:0]     lfsr_nxt;
  logic [W-1:0]     lfsr_word;

  // Round-robin pick: first active request scanning upward from the pointer
  always_comb begin
    found   = 1'b0;
    win     = '0;
    arb_idx = '0;
    for (int k = 0; k < N; k++) begin
      arb_idx = rr_q + IDW'(k);
      if (!found && req[arb_idx]) begin
        found = 1'b1;
        win   = arb_idx;
      end
    end
    prob_sel = prob[{win, 1'b0} +: 2];
  end

  rnd_mask_scheduler_lfsr_comb #(
    .W(W)
  ) u_lfsr (
    .seed        (seed_q),
    .probability (prob_sel),
    .nxt         (lfsr_nxt),
    .rnd         (lfsr_word)
  );

  // Next-state logic; seed_load overrides every state and aborts a pending word
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    out_d   = out_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    if (seed_load) begin
      seed_d  = seed_in;
      gnt_d   = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = (seed_in == '0) ? ST_LOCKED : ST_READY;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOCKED: ;
        ST_READY: begin
          if (found) begin
            seed_d      = lfsr_nxt;
            out_d       = lfsr_word;
            id_d        = win;
            gnt_d       = '0;
            gnt_d[win]  = 1'b1;
            valid_d     = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (rnd_ready) begin
            valid_d = 1'b0;
            gnt_d   = '0;
            rr_d    = id_q + 1'b1;
            if (cnt_q != CNT_W'(RESEED_INTERVAL)) begin
              cnt_d = cnt_q + 1'b1;
            end
            state_d = ST_READY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      seed_q  <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  assign gnt        = gnt_q;
  assign rnd_valid  = valid_q;
  assign rnd_out    = out_q;
  assign rnd_id     = id_q;
  assign reseed_req = (cnt_q == CNT_W'(RESEED_INTERVAL));
  assign locked     = (state_q == ST_LOCKED);

endmodule
